// File: rtl/tinyml_axi_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tinyml_axi_arbiter: registered N-port fixed/round-robin arbiter         |
// | Rev 1.0 - initial release                                               |
// +------------------------------------------------------------------------+
module tinyml_axi_arbiter #(
  parameter int    PORTS                = 4,
  parameter int    ARB_TYPE_ROUND_ROBIN = 0,
  parameter int    ARB_BLOCK            = 0,
  parameter int    ARB_BLOCK_ACK        = 1,
  parameter string LSB_PRIORITY         = "LOW"
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PORTS-1:0]         request,
  input  logic [PORTS-1:0]         acknowledge,
  output logic [PORTS-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(PORTS)-1:0] grant_encoded
);

  localparam int IW         = $clog2(PORTS);
  localparam bit c_lsb_high = (LSB_PRIORITY == "HIGH");

  logic [PORTS-1:0] grant_q, grant_d;
  logic [PORTS-1:0] mask_q, mask_d;
  logic [IW-1:0]    enc_q, enc_d;
  logic             valid_q, valid_d;

  logic [PORTS-1:0] w_masked_req;
  logic [IW-1:0]    w_win_idx;
  logic             w_req_any;
  logic             w_release;
  logic             w_arb_en;

  // Later loop iterations overwrite earlier ones, so the scan order sets priority.
  function automatic logic [IW-1:0] f_pick(input logic [PORTS-1:0] vec);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (c_lsb_high) begin
        if (vec[PORTS-1-i]) idx = IW'(PORTS-1-i);
      end else if (vec[i]) begin
        idx = IW'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [PORTS-1:0] f_mask(input logic [IW-1:0] idx);
    logic [PORTS-1:0] m;
    for (int i = 0; i < PORTS; i++) begin
      m[i] = c_lsb_high ? (i > int'(idx)) : (i < int'(idx));
    end
    return m;
  endfunction

  always_comb begin
    w_masked_req = request & mask_q;
    w_req_any    = |request;
    if ((ARB_TYPE_ROUND_ROBIN != 0) && (|w_masked_req)) begin
      w_win_idx = f_pick(w_masked_req);
    end else begin
      w_win_idx = f_pick(request);
    end

    w_release = (ARB_BLOCK_ACK != 0) ? (|(acknowledge & grant_q))
                                     : ~(|(request & grant_q));
    w_arb_en  = (ARB_BLOCK == 0) || !valid_q || w_release;

    grant_d = grant_q;
    enc_d   = enc_q;
    valid_d = valid_q;
    mask_d  = mask_q;
    if (w_arb_en) begin
      grant_d = w_req_any ? ({{(PORTS-1){1'b0}}, 1'b1} << w_win_idx) : '0;
      enc_d   = w_req_any ? w_win_idx : '0;
      valid_d = w_req_any;
      // Idle arbitration keeps the rotation history.
      if ((ARB_TYPE_ROUND_ROBIN != 0) && w_req_any) begin
        mask_d = f_mask(w_win_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_q <= '0;
      enc_q   <= '0;
      valid_q <= 1'b0;
      mask_q  <= '1;
    end else begin
      grant_q <= grant_d;
      enc_q   <= enc_d;
      valid_q <= valid_d;
      mask_q  <= mask_d;
    end
  end

  assign grant         = grant_q;
  assign grant_encoded = enc_q;
  assign grant_valid   = valid_q;

endmodule
`default_nettype wire
